line_bank_scheduler: RTL

//  Write/read scheduler for the 4-bank line-buffer memory in front of the image filter.

---
 rtl/line_bank_scheduler.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/line_bank_scheduler.sv
// line_bank_scheduler
// Write/read scheduler for a 4-bank line buffer. Writes lines round-robin
// into the banks, tracks how many committed lines are held, grants the
// filter a KERNEL_LINES-deep read window starting at the oldest bank, and
// retires one line per completed read pass.
//
// Handshake: i_rd_req is a level that the filter holds until it is granted.
// o_rd_grant is a combinational 1-clk pulse on the cycle that the read FSM
// moves R_IDLE -> R_HOLD. The filter ends its pass with a 1-clk i_rd_done.
// A frame-start i_vs overrides every other event in the same cycle.
module line_bank_scheduler #(
    parameter int MEM_ADDR_WIDTH = 11,
    parameter int HAC            = 1920,
    parameter int KERNEL_LINES   = 3,
    parameter int NUM_BANK       = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_vs,
    input  logic                      i_de,
    input  logic                      i_rd_req,
    input  logic                      i_rd_done,
    output logic [3:0]                o_mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] o_mem_waddr,
    output logic [1:0]                o_wr_bank,
    output logic [1:0]                o_rd_base_bank,
    output logic                      o_rd_grant,
    output logic [2:0]                o_lines_avail,
    output logic                      o_line_done,
    output logic                      o_ovf,
    output logic                      o_len_err
);

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_LINE, W_COMMIT} wr_state_t;
    typedef enum logic       {R_IDLE, R_HOLD} rd_state_t;

    // pix_cnt needs one extra bit so it can reach HAC and stay there
    localparam logic [MEM_ADDR_WIDTH:0]   HAC_L      = (MEM_ADDR_WIDTH+1)'(HAC);
    localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR  = MEM_ADDR_WIDTH'(HAC - 1);
    localparam logic [2:0]                KERNEL_L   = 3'(KERNEL_LINES);
    localparam logic [2:0]                FULL_COUNT = 3'(NUM_BANK);

    wr_state_t               wr_state, wr_next;
    rd_state_t               rd_state, rd_next;
    logic                    de_d;
    logic                    de_rise;
    logic                    line_start;
    logic                    pix_take;
    logic                    commit;
    logic                    retire;
    logic                    grant;
    logic                    drop;
    logic [1:0]              wr_bank;
    logic [1:0]              base;
    logic [2:0]              count;
    logic [3:0]              bank_oh;
    logic [MEM_ADDR_WIDTH:0] pix_cnt;

    assign de_rise = i_de & ~de_d;
    assign bank_oh = 4'b0001 << wr_bank;
    assign commit  = (wr_state == W_COMMIT) && !drop && !i_vs;

    // Write FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) wr_state <= W_IDLE;
        else       wr_state <= wr_next;
    end

    // Write FSM next state; i_vs restarts the frame from any state
    always_comb begin
        wr_next    = wr_state;
        line_start = 1'b0;
        pix_take   = 1'b0;
        if (i_vs) begin
            wr_next = W_WAIT;
        end else begin
            case (wr_state)
                W_IDLE:   wr_next = W_IDLE;
                W_WAIT: begin
                    if (de_rise) begin
                        wr_next    = W_LINE;
                        line_start = 1'b1;
                    end
                end
                W_LINE: begin
                    if (!i_de) wr_next  = W_COMMIT;
                    else       pix_take = 1'b1;
                end
                W_COMMIT: wr_next = W_WAIT;
                default:  wr_next = W_IDLE;
            endcase
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rd_state <= R_IDLE;
        else       rd_state <= rd_next;
    end

    // Read FSM next state plus grant/retire strobes
    always_comb begin
        rd_next = rd_state;
        grant   = 1'b0;
        retire  = 1'b0;
        if (i_vs) begin
            rd_next = R_IDLE;
        end else begin
            case (rd_state)
                R_IDLE: begin
                    if (i_rd_req && count >= KERNEL_L) begin
                        rd_next = R_HOLD;
                        grant   = 1'b1;
                    end
                end
                R_HOLD: begin
                    if (i_rd_done) begin
                        rd_next = R_IDLE;
                        retire  = 1'b1;
                    end
                end
                default: rd_next = R_IDLE;
            endcase
        end
    end

    // Previous de sample for rise detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) de_d <= 1'b0;
        else       de_d <= i_de;
    end

    // Bank pointers, line count, flags and the registered write port
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_bank     <= '0;
            base        <= '0;
            count       <= '0;
            drop        <= 1'b0;
            pix_cnt     <= '0;
            o_mem_we    <= '0;
            o_mem_waddr <= '0;
            o_ovf       <= 1'b0;
            o_len_err   <= 1'b0;
        end else if (i_vs) begin
            wr_bank   <= '0;
            base      <= '0;
            count     <= '0;
            drop      <= 1'b0;
            pix_cnt   <= '0;
            o_mem_we  <= '0;
            o_ovf     <= 1'b0;
            o_len_err <= 1'b0;
        end else begin
            if (commit) wr_bank <= wr_bank + 2'd1;
            if (retire) base    <= base + 2'd1;
            if (commit && !retire && count != FULL_COUNT) count <= count + 3'd1;
            if (retire && !commit && count != 3'd0)       count <= count - 3'd1;

            if (line_start) begin
                // a line that finds every bank held is dropped whole
                drop        <= (count == FULL_COUNT);
                o_ovf       <= o_ovf | (count == FULL_COUNT);
                o_mem_we    <= (count == FULL_COUNT) ? 4'b0000 : bank_oh;
                o_mem_waddr <= '0;
                pix_cnt     <= (MEM_ADDR_WIDTH+1)'(1);
            end else if (pix_take) begin
                if (pix_cnt < HAC_L) begin
                    o_mem_we    <= drop ? 4'b0000 : bank_oh;
                    o_mem_waddr <= pix_cnt[MEM_ADDR_WIDTH-1:0];
                    pix_cnt     <= pix_cnt + 1'b1;
                end else begin
                    // overlong line: stop writing, pin address, keep line
                    o_mem_we    <= 4'b0000;
                    o_mem_waddr <= LAST_ADDR;
                    o_len_err   <= 1'b1;
                end
            end else begin
                o_mem_we <= 4'b0000;
            end
        end
    end

    assign o_wr_bank      = wr_bank;
    assign o_rd_base_bank = base;
    assign o_lines_avail  = count;
    assign o_rd_grant     = grant;
    assign o_line_done    = commit;

endmodule
